// File: rtl/riscv_pkg.sv
// Shared pipeline types for the memory-port arbiter.
package riscv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Round-robin pick between fetch and data requests; lastd=1 means data won last.
module mem_arb_pick (
  input  logic ifreq,
  input  logic dreq,
  input  logic lastd,
  output logic grant_d,
  output logic grant_f
);
  assign grant_d = dreq  & (~ifreq | ~lastd);
  assign grant_f = ifreq & (~dreq  |  lastd);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between IF and MEM, one access at a time,
// with a kill flag that swallows a fetch result after a branch flush.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifreq,
  input  logic [AW-1:0]     ifaddr,
  input  logic              ifkill,
  output logic              ifvalid,
  output logic [XLEN-1:0]   ifrdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [AW-1:0]     daddr,
  input  logic [XLEN-1:0]   dwdata,
  input  logic [XLEN/8-1:0] dbe,
  output logic              dvalid,
  output logic [XLEN-1:0]   drdata,
  output logic              stallf,
  output logic              stallm,
  output logic              memreq,
  output logic              memwe,
  output logic [AW-1:0]     memaddr,
  output logic [XLEN-1:0]   memwdata,
  output logic [XLEN/8-1:0] memben,
  input  logic              memready,
  input  logic [XLEN-1:0]   memrdata
);
  arb_state_t state;
  logic       lastd;
  logic       killed;
  logic       grant_d, grant_f;

  mem_arb_pick u_pick (
    .ifreq  (ifreq),
    .dreq   (dreq),
    .lastd  (lastd),
    .grant_d(grant_d),
    .grant_f(grant_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      memreq   <= 1'b0;
      memwe    <= 1'b0;
      memaddr  <= '0;
      memwdata <= '0;
      memben   <= '0;
      lastd    <= 1'b0;
      killed   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= DATA;
            memreq   <= 1'b1;
            memwe    <= dwe;
            memaddr  <= daddr;
            memwdata <= dwdata;
            memben   <= dbe;
            lastd    <= 1'b1;
          end else if (grant_f) begin
            state   <= FETCH;
            memreq  <= 1'b1;
            memwe   <= 1'b0;
            memaddr <= ifaddr;
            memben  <= '0;
            lastd   <= 1'b0;
          end
        end
        FETCH: begin
          // The access always runs to completion; a flush only hides its result.
          if (ifkill) killed <= 1'b1;
          if (memready) begin
            state  <= IDLE;
            memreq <= 1'b0;
            killed <= 1'b0;
          end
        end
        DATA: begin
          if (memready) begin
            state  <= IDLE;
            memreq <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          memreq <= 1'b0;
        end
      endcase
    end
  end

  assign ifvalid = (state == FETCH) & memready & ~killed & ~ifkill;
  assign dvalid  = (state == DATA) & memready;
  assign ifrdata = memrdata;
  assign drdata  = memrdata;
  assign stallf  = ifreq & ~ifvalid;
  assign stallm  = dreq & ~dvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, tie alternation, flush, store,
// async reset mid-access and back-to-back fetches.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifreq, ifkill, dreq, dwe, memready;
  logic [31:0] ifaddr, daddr, dwdata, memrdata;
  logic [3:0]  dbe;
  logic        ifvalid, dvalid, stallf, stallm, memreq, memwe;
  logic [31:0] ifrdata, drdata, memaddr, memwdata;
  logic [3:0]  memben;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_d, exp_f;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifreq(ifreq), .ifaddr(ifaddr), .ifkill(ifkill),
    .ifvalid(ifvalid), .ifrdata(ifrdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dvalid(dvalid), .drdata(drdata),
    .stallf(stallf), .stallm(stallm),
    .memreq(memreq), .memwe(memwe), .memaddr(memaddr),
    .memwdata(memwdata), .memben(memben),
    .memready(memready), .memrdata(memrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ifreq = 0; ifkill = 0; dreq = 0; dwe = 0; memready = 0;
    ifaddr = 0; daddr = 0; dwdata = 0; memrdata = 0; dbe = 0;
    cyc(); cyc();
    smp();
    chk("rst_memreq", memreq, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memwe", memwe, 0);
    chk("rst_memben", memben, 0);
    chk("rst_ifvalid", ifvalid, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_stallf", stallf, 0);
    chk("rst_stallm", stallm, 0);
    cyc();
    rst_n = 1'b1;

    // single load, memready three cycles after memreq
    cyc();
    dreq = 1; daddr = 32'h100; dwe = 0;
    smp(); chk("ld_idle_stallm", stallm, 1);
    cyc(); smp();
    chk("ld_memreq", memreq, 1);
    chk("ld_memaddr", memaddr, 32'h100);
    chk("ld_memwe", memwe, 0);
    cyc(); smp(); chk("ld_wait_stallm", stallm, 1);
    cyc(); smp(); chk("ld_wait_dvalid", dvalid, 0);
    cyc(); memready = 1; memrdata = 32'h1234_5678;
    smp();
    chk("ld_dvalid", dvalid, 1);
    chk("ld_drdata", drdata, 32'h1234_5678);
    chk("ld_stallm_off", stallm, 0);
    cyc(); memready = 0; dreq = 0;
    smp();
    chk("ld_idle_memreq", memreq, 0);
    chk("ld_dvalid_pulse", dvalid, 0);

    // reset pulse so the tie starts with lastd=0
    cyc(); rst_n = 0; cyc(); rst_n = 1;

    // tie: both held, grants alternate D,F,D,F
    cyc();
    ifreq = 1; dreq = 1; dwe = 0;
    exp_d = 32'h300; exp_f = 32'h200;
    daddr = exp_d; ifaddr = exp_f;
    for (int g = 0; g < 4; g++) begin
      smp();
      chk("tie_idle_memreq", memreq, 0);
      chk("tie_idle_stallf", stallf, 1);
      chk("tie_idle_stallm", stallm, 1);
      cyc(); smp();
      chk("tie_memreq", memreq, 1);
      chk("tie_memaddr", memaddr, (g % 2 == 0) ? exp_d : exp_f);
      memready = 1; memrdata = 32'hA000 + g;
      #1;
      chk("tie_dvalid", dvalid, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk("tie_ifvalid", ifvalid, (g % 2 == 0) ? 1'b0 : 1'b1);
      chk("tie_rdata", (g % 2 == 0) ? drdata : ifrdata, 32'hA000 + g);
      cyc();
      memready = 0;
      if (g % 2 == 0) begin exp_d = exp_d + 4; daddr = exp_d; end
      else begin exp_f = exp_f + 4; ifaddr = exp_f; end
    end
    ifreq = 0; dreq = 0;

    // flush while a fetch is in flight (last grant was FETCH)
    cyc();
    ifreq = 1; ifaddr = 32'h40;
    smp(); chk("fl_stallf", stallf, 1);
    cyc(); smp();
    chk("fl_memaddr", memaddr, 32'h40);
    chk("fl_memwe", memwe, 0);
    cyc(); ifkill = 1;
    smp(); chk("fl_kill_ifvalid", ifvalid, 0);
    cyc(); ifkill = 0; memready = 1; memrdata = 32'h13;
    smp();
    chk("fl_killed_ifvalid", ifvalid, 0);
    chk("fl_killed_memreq", memreq, 1);
    chk("fl_killed_stallf", stallf, 1);
    cyc(); memready = 0; ifaddr = 32'h80;
    smp(); chk("fl_back_idle", memreq, 0);
    cyc(); smp();
    chk("fl_next_memaddr", memaddr, 32'h80);
    memready = 1; memrdata = 32'h93;
    #1;
    chk("fl_next_ifvalid", ifvalid, 1);
    chk("fl_next_ifrdata", ifrdata, 32'h93);
    chk("fl_next_stallf", stallf, 0);
    cyc(); memready = 0; ifreq = 0;

    // same-cycle kill and completion
    cyc(); ifreq = 1; ifaddr = 32'hC0;
    cyc(); smp();
    memready = 1; ifkill = 1;
    #1;
    chk("fl_same_ifvalid", ifvalid, 0);
    cyc(); memready = 0; ifkill = 0; ifreq = 0;
    smp(); chk("fl_same_idle", memreq, 0);

    // store: fields held while the requester's inputs change
    cyc();
    dreq = 1; dwe = 1; dbe = 4'b0011; dwdata = 32'hDEAD_BEEF; daddr = 32'h500;
    cyc();
    daddr = 32'h999; dwdata = 32'h0; dbe = 4'hF; dwe = 0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("st_memaddr", memaddr, 32'h500);
      chk("st_memwe", memwe, 1);
      chk("st_memben", memben, 4'b0011);
      chk("st_memwdata", memwdata, 32'hDEAD_BEEF);
      chk("st_dvalid", dvalid, 0);
      chk("st_stallm", stallm, 1);
      cyc();
    end
    memready = 1;
    smp();
    chk("st_done_dvalid", dvalid, 1);
    chk("st_done_stallm", stallm, 0);
    cyc(); memready = 0; dreq = 0;
    smp();
    chk("st_pulse", dvalid, 0);
    chk("st_idle", memreq, 0);

    // async reset mid-access
    cyc();
    dreq = 1; dwe = 0; daddr = 32'h600;
    cyc(); smp();
    chk("rm_memreq", memreq, 1);
    rst_n = 0;
    #1;
    chk("rm_async_memreq", memreq, 0);
    chk("rm_async_memaddr", memaddr, 0);
    chk("rm_async_memwdata", memwdata, 0);
    chk("rm_async_memben", memben, 0);
    dreq = 0;
    cyc(); rst_n = 1;
    smp();
    chk("rm_rel_memreq", memreq, 0);
    chk("rm_rel_stallm", stallm, 0);
    chk("rm_rel_dvalid", dvalid, 0);
    chk("rm_rel_memaddr", memaddr, 0);
    // lastd cleared: data wins the tie again
    cyc();
    ifreq = 1; dreq = 1; daddr = 32'h700; ifaddr = 32'h800;
    cyc(); smp();
    chk("rm_tie_memaddr", memaddr, 32'h700);
    memready = 1;
    cyc(); memready = 0; ifreq = 0; dreq = 0;

    // back-to-back fetches with memready tied high
    cyc();
    ifreq = 1; ifaddr = 32'h1000; memready = 1; memrdata = 32'hF00;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("bb_idle_ifvalid", ifvalid, 0);
      cyc(); smp();
      chk("bb_ifvalid", ifvalid, 1);
      chk("bb_memaddr", memaddr, 32'h1000 + 4 * i);
      cyc();
      ifaddr = 32'h1000 + 4 * (i + 1);
    end
    ifreq = 0; memready = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
